shift_arbiter: RTL and testbench

Shares one 32-bit barrel shifter between two requesters (port 0: integer pipeline ALU path, port 1: multi-cycle/auxiliary unit) using valid/ready handshakes and round-robin arbitration. Each accepted request is shifted combinationally and its result is captured in a single registered output slot tagged with the requester ID. The slot is held until the consumer accepts it, so back-pressure propagates cleanly to both requesters.

---
 rtl/shift_arbiter_pkg.sv | 19 +
 rtl/shift_arbiter_shifter.sv | 22 ++
 rtl/shift_arbiter.sv | 99 +++++++++
 tb/tb_shift_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: operand widths and shift-type codes.
// The ALU decoder uses the same shift-type constants.
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SHIFT_SRL  = 2'b00;
  localparam logic [1:0] SHIFT_SLL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_PASS = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 32-bit barrel shifter: logical right, left, arithmetic right or pass-through.
module shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         type_i,
  output logic [DATA_W-1:0]  r_o
);

  always_comb begin
    r_o = a_i;
    case (type_i)
      SHIFT_SRL:  r_o = a_i >> shamt_i;
      SHIFT_SLL:  r_o = a_i << shamt_i;
      SHIFT_SRA:  r_o = $signed(a_i) >>> shamt_i;
      SHIFT_PASS: r_o = a_i;
      default:    r_o = a_i;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one barrel shifter through round-robin arbitration and a
// single registered result slot; back-pressure on the slot stalls both requesters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// A requester holds valid and operands until ready; the slot holds rsp_* until rsp_ready.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_type,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_type,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_r
);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] rsp_r_q,     rsp_r_d;
  logic              last_grant_q, last_grant_d;

  logic              can_accept;
  logic              grant0, grant1;
  shift_req_t        sel_req;
  logic [DATA_W-1:0] shift_r;

  // Slot refills when empty or when it drains in the same cycle.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // The port that did not win last time has priority under contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && can_accept) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  always_comb begin
    sel_req = '{a: req0_a, shamt: req0_shamt, op: req0_type};
    if (grant1) begin
      sel_req = '{a: req1_a, shamt: req1_shamt, op: req1_type};
    end
  end

  shifter u_shifter (
    .a_i     (sel_req.a),
    .shamt_i (sel_req.shamt),
    .type_i  (sel_req.op),
    .r_o     (shift_r)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    last_grant_d = last_grant_q;
    if (grant0 || grant1) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_r_d      = shift_r;
      last_grant_d = grant1;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_r      = rsp_r_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of the arbiter and result slot.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req1_a = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic [1:0]  req0_type = '0, req1_type = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [31:0] rsp_r;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid, m_id, m_last;
  logic [31:0] m_r;
  logic [31:0] exp_q[$];

  logic o_r0, o_r1, e_r0, e_r1;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_shamt (req0_shamt),
    .req0_type  (req0_type),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_shamt (req1_shamt),
    .req1_type  (req1_type),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r)
  );

  // Bit-by-bit shift from the rules: each result bit pulls from a source bit or the fill.
  function automatic logic [31:0] ref_shift(logic [31:0] a, int sh, logic [1:0] t);
    logic [31:0] r;
    if (t == 2'b11) return a;
    for (int i = 0; i < 32; i++) begin
      int src;
      src = (t == 2'b01) ? i - sh : i + sh;
      if (src >= 0 && src < 32) r[i] = a[src];
      else r[i] = (t == 2'b10) ? a[31] : 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_r     = '0;
    m_last  = 1'b1;
    exp_q.delete();
  endtask

  // Samples the readies for the currently driven inputs, advances one clock,
  // then updates the model with the grant the rules call for.
  task automatic tick();
    logic can;
    #1;
    o_r0 = req0_ready;
    o_r1 = req1_ready;
    can  = !m_valid || rsp_ready;
    e_r0 = can && req0_valid && (!req1_valid || m_last == 1'b1);
    e_r1 = can && req1_valid && (!req0_valid || m_last == 1'b0);
    @(posedge clk);
    #1;
    if (e_r0 || e_r1) begin
      m_valid = 1'b1;
      m_id    = e_r1;
      m_r     = e_r1 ? ref_shift(req1_a, req1_shamt, req1_type)
                     : ref_shift(req0_a, req0_shamt, req0_type);
      m_last  = e_r1;
      exp_q.push_back(m_r);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    #2;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", req1_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
    total++; if (rsp_r !== 32'h0) begin bad++; $display("FAIL reset_rsp_r got=%h want=0", rsp_r); end
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_port0();
    req0_valid = 1'b1; req0_a = 32'h8000_0001; req0_shamt = 5'd4; req0_type = 2'b10;
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    total++; if (o_r0 !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b want=1", o_r0); end
    total++; if (o_r1 !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b want=0", o_r1); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%b want=0", rsp_id); end
    total++; if (rsp_r !== 32'hF800_0000) begin bad++; $display("FAIL single_r got=%h want=f8000000", rsp_r); end
    idle_inputs();
    tick();
  endtask

  task automatic test_alternate();
    logic prev;
    int   ngrant;
    ngrant = 0;
    prev   = 1'b0;
    req1_a = 32'h0000_00FF; req1_shamt = 5'd8; req1_type = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_a = $urandom; req0_shamt = 5'($urandom_range(0, 31)); req0_type = 2'($urandom_range(0, 3));
      tick();
      total++; if ({o_r0, o_r1} !== {e_r0, e_r1}) begin bad++; $display("FAIL alt_grant cyc=%0d got=%b%b want=%b%b", i, o_r0, o_r1, e_r0, e_r1); end
      if (ngrant > 0) begin
        total++; if (o_r1 !== !prev) begin bad++; $display("FAIL alt_order cyc=%0d got=%b want=%b", i, o_r1, !prev); end
      end
      prev = o_r1;
      ngrant++;
      total++; if (rsp_r !== m_r || rsp_id !== m_id) begin bad++; $display("FAIL alt_rsp cyc=%0d got=%h/%b want=%h/%b", i, rsp_r, rsp_id, m_r, m_id); end
      if (m_id == 1'b1) begin
        total++; if (rsp_r !== 32'h0000_FF00) begin bad++; $display("FAIL alt_port1_r got=%h want=0000ff00", rsp_r); end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_r;
    logic        held_id;
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_shamt = 5'd3; req0_type = 2'b00;
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    held_r  = m_r;
    held_id = m_id;
    req1_valid = 1'b1; req1_a = 32'hCAFE_0000; req1_shamt = 5'd16; req1_type = 2'b00;
    req0_a = 32'h0F0F_0F0F;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_r0 !== 1'b0 || o_r1 !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b%b want=00", i, o_r0, o_r1); end
      total++; if (rsp_valid !== 1'b1 || rsp_r !== held_r || rsp_id !== held_id) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b %h/%b want=1 %h/%b", i, rsp_valid, rsp_r, rsp_id, held_r, held_id); end
    end
    rsp_ready = 1'b1;
    tick();
    total++; if (o_r1 !== 1'b1 || o_r0 !== 1'b0) begin bad++; $display("FAIL bp_refill got=%b%b want=01", o_r0, o_r1); end
    total++; if (rsp_valid !== 1'b1 || rsp_r !== 32'h0000_CAFE || rsp_id !== 1'b1) begin bad++; $display("FAIL bp_refill_rsp got=%b %h/%b want=1 0000cafe/1", rsp_valid, rsp_r, rsp_id); end
    idle_inputs();
    tick();
  endtask

  task automatic test_boundaries();
    logic [31:0] va[6];
    logic [4:0]  vs[6];
    logic [1:0]  vt[6];
    logic [31:0] vr[6];
    va = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1357_9BDF};
    vs = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd7};
    vt = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    vr = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 32'h1357_9BDF};
    req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_a = va[i]; req0_shamt = vs[i]; req0_type = vt[i];
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_r !== vr[i]) begin bad++; $display("FAIL boundary case=%0d got=%b %h want=1 %h", i, rsp_valid, rsp_r, vr[i]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_withdraw();
    req0_valid = 1'b1; req0_a = 32'h0000_0010; req0_shamt = 5'd1; req0_type = 2'b01;
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_0000; req1_shamt = 5'd4; req1_type = 2'b10;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (o_r1 !== 1'b0) begin bad++; $display("FAIL wd_blocked cyc=%0d got=%b want=0", i, o_r1); end
    end
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_r !== 32'h0000_0020) begin bad++; $display("FAIL wd_no_result got=%b %b %h want=0 0 00000020", rsp_valid, rsp_id, rsp_r); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    total++; if (o_r0 !== 1'b0 || o_r1 !== 1'b1) begin bad++; $display("FAIL wd_last_grant got=%b%b want=01", o_r0, o_r1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_shamt = 5'($urandom_range(0, 31)); req0_type = 2'($urandom_range(0, 3));
      req1_a = $urandom; req1_shamt = 5'($urandom_range(0, 31)); req1_type = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
      total++; if ({o_r0, o_r1} !== {e_r0, e_r1}) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b%b want=%b%b", i, o_r0, o_r1, e_r0, e_r1); end
      total++; if (rsp_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, rsp_valid, m_valid); end
      if (m_valid) begin
        total++; if (rsp_r !== m_r || rsp_id !== m_id) begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%h/%b want=%h/%b", i, rsp_r, rsp_id, m_r, m_id); end
      end
    end
    total++; if (exp_q.size() < 50) begin bad++; $display("FAIL rnd_activity got=%0d want>=50", exp_q.size()); end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    req0_valid = 1'b1; req0_a = 32'hA5A5_A5A5; req0_shamt = 5'd2; req0_type = 2'b00;
    req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ar_precond got=%b want=1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_r !== 32'h0) begin bad++; $display("FAIL ar_immediate got=%b %h want=0 0", rsp_valid, rsp_r); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b want=0", req0_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req1_a = 32'h0000_0001; req1_shamt = 5'd1; req1_type = 2'b01;
    tick();
    total++; if (o_r0 !== 1'b1 || o_r1 !== 1'b0) begin bad++; $display("FAIL ar_first_grant got=%b%b want=10", o_r0, o_r1); end
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_r !== 32'h2969_6969) begin bad++; $display("FAIL ar_first_rsp got=%b %b %h want=1 0 29696969", rsp_valid, rsp_id, rsp_r); end
    idle_inputs();
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_port0();
    test_alternate();
    test_backpressure();
    test_boundaries();
    test_withdraw();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
